// File: rtl/mem_pkg.sv
// Shared funct3 size codes, responder FSM states and byte-strobe/legality helpers.
// Pure combinational definitions; no latency or flow control of their own.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << lane;
      F3_H, F3_HU: be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  // Stores only have signed-looking encodings; the unsigned codes are load-only.
  function automatic logic access_err(input logic is_store, input logic [2:0] f3,
                                      input logic [1:0] lane);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = lane[0];
      F3_W:    err = |lane;
      F3_BU:   err = is_store;
      F3_HU:   err = is_store | lane[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM with four byte lanes; write lands on the clock edge, read is combinational.
// Latency: read follows the index in the same cycle; no backpressure, caller sequences accesses.
module data_ram
  import mem_pkg::*;
#(
  parameter int DM_ADDRESS = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [3:0]            wr_be,
  input  logic [DM_ADDRESS-1:0] idx,
  input  logic [31:0]           wr_dat,
  output logic [31:0]           rd_dat
);

  logic [31:0] ram_q [2**DM_ADDRESS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          ram_q[idx][8*i +: 8] <= wr_dat[8*i +: 8];
        end
      end
    end
  end

  assign rd_dat = ram_q[idx];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: latches a request, waits WAIT_CYCLES, then accesses the RAM (latency WAIT_CYCLES+2).
// Backpressure: MemStallOut holds the upstream register from request accept until the DONE cycle.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRdEnIn,
  input  logic              MemWrtEnIn,
  input  logic [2:0]        funct3In,
  input  logic [DATA_W-1:0] MemWrtAddressIn,
  input  logic [DATA_W-1:0] MemWrtDataIn,
  output logic [DATA_W-1:0] MemRdDataOut,
  output logic              MemRdValidOut,
  output logic              MemStallOut,
  output logic              MemErrOut
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [2:0]            f3_q, f3_d;
  logic [DM_ADDRESS+1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdat_q, wdat_d;
  logic [DATA_W-1:0]     rd_dat_q, rd_dat_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  err_q, err_d;

  logic              req;
  logic              acc_err;
  logic              ram_we;
  logic [3:0]        be;
  logic [DATA_W-1:0] ram_wdat;
  logic [DATA_W-1:0] ram_rdat;
  logic [DATA_W-1:0] load_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic              unused_addr;

  // Upper address bits fall outside the RAM and simply wrap.
  assign unused_addr = ^MemWrtAddressIn[DATA_W-1:DM_ADDRESS+2];

  assign req         = MemRdEnIn | MemWrtEnIn;
  assign MemStallOut = ((state_q == IDLE) & req) | (state_q == BUSY);

  assign acc_err = access_err(wr_q, f3_q, addr_q[1:0]);
  assign be      = byte_en(f3_q, addr_q[1:0]);
  assign ram_we  = (state_q == DONE) & wr_q & ~acc_err & ~rst;

  always_comb begin
    case (f3_q)
      F3_B:    ram_wdat = {4{wdat_q[7:0]}};
      F3_H:    ram_wdat = {2{wdat_q[15:0]}};
      default: ram_wdat = wdat_q;
    endcase
  end

  data_ram #(.DM_ADDRESS(DM_ADDRESS)) u_ram (
    .clk    (clk),
    .wr_en  (ram_we),
    .wr_be  (be),
    .idx    (addr_q[DM_ADDRESS+1:2]),
    .wr_dat (ram_wdat),
    .rd_dat (ram_rdat)
  );

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = ram_rdat[7:0];
      2'd1:    ld_byte = ram_rdat[15:8];
      2'd2:    ld_byte = ram_rdat[23:16];
      default: ld_byte = ram_rdat[31:24];
    endcase
    ld_half = addr_q[1] ? ram_rdat[31:16] : ram_rdat[15:0];
    case (f3_q)
      F3_B:    load_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      F3_BU:   load_ext = {{(DATA_W-8){1'b0}}, ld_byte};
      F3_H:    load_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
      F3_HU:   load_ext = {{(DATA_W-16){1'b0}}, ld_half};
      default: load_ext = ram_rdat;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    rd_dat_d = rd_dat_q;
    rd_vld_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          // A simultaneous read+write is a store and never reports load data.
          rd_d    = MemRdEnIn & ~MemWrtEnIn;
          wr_d    = MemWrtEnIn;
          f3_d    = funct3In;
          addr_d  = MemWrtAddressIn[DM_ADDRESS+1:0];
          wdat_d  = MemWrtDataIn;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES > 0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (acc_err) begin
          err_d    = 1'b1;
          rd_dat_d = '0;
        end else if (rd_q) begin
          rd_vld_d = 1'b1;
          rd_dat_d = load_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      f3_q     <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
      err_q    <= err_d;
    end
  end

  assign MemRdDataOut  = rd_dat_q;
  assign MemRdValidOut = rd_vld_q;
  assign MemErrOut     = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 1, 3, 0), directed table, corner sequences,
// and random traffic checked against a byte-addressed reference memory.
module tb_data_mem_responder;

  localparam int ND = 3;

  logic        clk = 1'b0;
  logic        rst_a   [ND];
  logic        rd_en   [ND];
  logic        wr_en   [ND];
  logic [2:0]  f3_in   [ND];
  logic [31:0] addr_in [ND];
  logic [31:0] wdat_in [ND];
  logic [31:0] rd_dat  [ND];
  logic        rd_vld  [ND];
  logic        stall   [ND];
  logic        err     [ND];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  mm   [ND][2048];
  bit          kn   [ND][2048];
  logic [31:0] last [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_mem_responder #(
      .DATA_W      (32),
      .DM_ADDRESS  (9),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk             (clk),
      .rst             (rst_a[g]),
      .MemRdEnIn       (rd_en[g]),
      .MemWrtEnIn      (wr_en[g]),
      .funct3In        (f3_in[g]),
      .MemWrtAddressIn (addr_in[g]),
      .MemWrtDataIn    (wdat_in[g]),
      .MemRdDataOut    (rd_dat[g]),
      .MemRdValidOut   (rd_vld[g]),
      .MemStallOut     (stall[g]),
      .MemErrOut       (err[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, size/sign rules applied with plain arithmetic.
  function automatic void model(input int d, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] ed, output logic ev, output logic ee,
                                output bit ok);
    int sz;
    bit sgn, bad;
    int base;
    logic [31:0] v;
    sgn = 0;
    case (f3)
      3'b000:  begin sz = 1; sgn = 1; end
      3'b001:  begin sz = 2; sgn = 1; end
      3'b010:  sz = 4;
      3'b100:  sz = 1;
      3'b101:  sz = 2;
      default: sz = 0;
    endcase
    bad = (sz == 0) || (wr && f3[2]);
    if (!bad && ((a % 32'(sz)) != 0)) bad = 1;
    base = int'(a % 32'd2048);
    ok = 1;
    if (bad) begin
      ed = 0; ev = 0; ee = 1; last[d] = 0;
    end else if (wr) begin
      for (int i = 0; i < sz; i++) begin
        mm[d][base+i] = wd[8*i +: 8];
        kn[d][base+i] = 1;
      end
      ed = last[d]; ev = 0; ee = 0;
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) begin
        v  = v | (32'(mm[d][base+i]) << (8*i));
        ok = ok && kn[d][base+i];
      end
      if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      last[d] = v; ed = v; ev = 1; ee = 0;
    end
  endfunction

  task automatic access(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] o_d, output logic o_v, output logic o_e,
                        output int sn, output int lat, output logic clean);
    int c0;
    @(negedge clk);
    rd_en[d] = rd; wr_en[d] = wr; f3_in[d] = f3; addr_in[d] = a; wdat_in[d] = wd;
    c0 = cyc;
    #1;
    sn = 0;
    while (stall[d] && sn < 40) begin
      sn++;
      @(negedge clk); #1;
    end
    rd_en[d] = 0; wr_en[d] = 0; f3_in[d] = 0; addr_in[d] = 0; wdat_in[d] = 0;
    @(negedge clk); #1;
    lat = cyc - c0;
    o_d = rd_dat[d]; o_v = rd_vld[d]; o_e = err[d];
    @(negedge clk); #1;
    clean = !rd_vld[d] && !err[d];
  endtask

  task automatic run(input int d, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input bit cmp_model,
                     input string tag, output logic [31:0] o_d, output logic o_v, output logic o_e);
    logic [31:0] ed;
    logic ev, ee, clean;
    bit ok;
    int sn, lat;
    model(d, wr, f3, a, wd, ed, ev, ee, ok);
    access(d, rd, wr, f3, a, wd, o_d, o_v, o_e, sn, lat, clean);
    check({tag, " stall_cycles"}, 32'(sn), 32'(wait_of(d) + 1));
    check({tag, " latency"}, 32'(lat), 32'(wait_of(d) + 2));
    check({tag, " single_pulse"}, {31'd0, clean}, 32'd1);
    if (cmp_model) begin
      if (ok) check({tag, " data"}, o_d, ed);
      check({tag, " valid"}, {31'd0, o_v}, {31'd0, ev});
      check({tag, " err"}, {31'd0, o_e}, {31'd0, ee});
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ev;
    logic        ee;
  } vec_t;

  vec_t tbl [20];
  logic [2:0] f3s [10];

  initial begin
    logic [31:0] od, r;
    logic ov, oe, rw, rr;
    for (int d = 0; d < ND; d++) begin
      rst_a[d] = 1; rd_en[d] = 0; wr_en[d] = 0; f3_in[d] = 0;
      addr_in[d] = 0; wdat_in[d] = 0; last[d] = 0;
    end
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110};

    tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'h8081F0F0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFF0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'b100, 32'h11, 32'h0,        32'h000000F0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8081, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'b101, 32'h12, 32'h0,        32'h00008081, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h00000080, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 3'b000, 32'h21, 32'h000000AA, 32'h00000080, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h00000080, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'hBEEFAA44, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 3'b010, 32'h22, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 3'b001, 32'h23, 32'h00000055, 32'h0,        1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'hBEEFAA44, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 3'b100, 32'h20, 32'h000000FF, 32'h0,        1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 3'b010, 32'h44, 32'h01020304, 32'h0,        1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 3'b010, 32'h44, 32'h0,        32'h01020304, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'hBEEFAA44, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("reset data[%0d]", d),  rd_dat[d], 32'h0);
      check($sformatf("reset valid[%0d]", d), {31'd0, rd_vld[d]}, 32'd0);
      check($sformatf("reset err[%0d]", d),   {31'd0, err[d]}, 32'd0);
      check($sformatf("reset stall[%0d]", d), {31'd0, stall[d]}, 32'd0);
      rst_a[d] = 0;
    end

    // Directed vectors on the WAIT_CYCLES=1 instance.
    for (int i = 0; i < 20; i++) begin
      run(0, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, 1'b0,
          $sformatf("vec%0d", i), od, ov, oe);
      check($sformatf("vec%0d data", i),  od, tbl[i].ed);
      check($sformatf("vec%0d valid", i), {31'd0, ov}, {31'd0, tbl[i].ev});
      check($sformatf("vec%0d err", i),   {31'd0, oe}, {31'd0, tbl[i].ee});
    end

    // Address wrap with zero wait states.
    run(2, 1'b0, 1'b1, 3'b010, 32'h800, 32'hCAFEF00D, 1'b1, "wrap_sw", od, ov, oe);
    run(2, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, "wrap_lw", od, ov, oe);
    check("wrap_lw literal", od, 32'hCAFEF00D);

    // Reset in the second BUSY cycle abandons the store.
    run(1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h0BADF00D, 1'b1, "pre_rst_sw", od, ov, oe);
    @(negedge clk);
    wr_en[1] = 1; f3_in[1] = 3'b010; addr_in[1] = 32'h30; wdat_in[1] = 32'h12345678;
    #1 check("rst_seq stall_req", {31'd0, stall[1]}, 32'd1);
    @(negedge clk);
    #1 check("rst_seq stall_busy1", {31'd0, stall[1]}, 32'd1);
    @(negedge clk);
    rst_a[1] = 1; wr_en[1] = 0;
    @(negedge clk);
    #1;
    check("rst_seq stall_after", {31'd0, stall[1]}, 32'd0);
    check("rst_seq data_after", rd_dat[1], 32'h0);
    check("rst_seq valid_after", {31'd0, rd_vld[1]}, 32'd0);
    check("rst_seq err_after", {31'd0, err[1]}, 32'd0);
    rst_a[1] = 0;
    last[1] = 0;
    repeat (4) begin
      @(negedge clk); #1;
      check("rst_seq quiet", {31'd0, rd_vld[1] | err[1] | stall[1]}, 32'd0);
    end
    run(1, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b1, "post_rst_lw", od, ov, oe);
    check("post_rst_lw literal", od, 32'h0BADF00D);

    // Random traffic on the WAIT_CYCLES=1 and =0 instances over preloaded regions.
    for (int d = 0; d < ND; d += 2) begin
      for (int i = 0; i < 16; i++) begin
        run(d, 1'b0, 1'b1, 3'b010, 32'h100 + 32'(4*i), $urandom, 1'b1,
            $sformatf("init%0d_%0d", d, i), od, ov, oe);
      end
      for (int i = 0; i < ((d == 0) ? 60 : 30); i++) begin
        r  = $urandom;
        rw = 1'($urandom_range(0, 1));
        rr = !rw || ($urandom_range(0, 5) == 0);
        run(d, rr, rw, f3s[$urandom_range(0, 9)],
            {r[31:11], 11'h100 + 11'($urandom_range(0, 63))}, $urandom, 1'b1,
            $sformatf("rand%0d_%0d", d, i), od, ov, oe);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
